counter_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit loadable up-counter between `NUM_REQ` requesters. Each requester posts either a load (with an 8-bit value) or an increment. The block drives the counter's `data_in`/`ld`/`inc` controls for exactly one cycle per granted operation, samples the counter's `q` after the update, and returns it to the owner with a done pulse. It sits between the requesting agents and the counter, and is the only driver of the counter's control inputs.

---
 rtl/counter_arbiter.sv | 161 ++++++++++++++++
 tb/tb_counter_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Round-robin sequencer that shares one 8-bit loadable up-counter between
// NUM_REQ requesters. Each granted operation drives the counter controls for
// one cycle, then returns the updated counter value to its owner with a done
// pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a request; may show done of previous operation
// ISSUE   | counter controls and gnt asserted for the latched owner
// CAPTURE | controls low, counter q holds post-update value
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_ld,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 done,
    output logic [ID_W-1:0]      done_id,
    output logic [7:0]           rsp_q,
    output logic                 rsp_wrap,
    output logic                 busy,
    output logic [7:0]           cntr_data_in,
    output logic                 cntr_ld,
    output logic                 cntr_inc,
    input  logic [7:0]           cntr_q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [ID_W-1:0]     owner, owner_nxt;
    logic                op_ld, op_ld_nxt;
    logic [7:0]          op_data, op_data_nxt;

    logic [NUM_REQ-1:0]  gnt_nxt;
    logic                done_nxt;
    logic [ID_W-1:0]     done_id_nxt;
    logic [7:0]          rsp_q_nxt;
    logic                rsp_wrap_nxt;
    logic                busy_nxt;
    logic [7:0]          cntr_data_in_nxt;
    logic                cntr_ld_nxt;
    logic                cntr_inc_nxt;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [7:0]          data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_arr[g] = req_data[8*g +: 8];
    end

    // Round-robin search: first set req bit starting at ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt        = state;
        ptr_nxt          = ptr;
        owner_nxt        = owner;
        op_ld_nxt        = op_ld;
        op_data_nxt      = op_data;
        gnt_nxt          = '0;
        done_nxt         = 1'b0;
        done_id_nxt      = done_id;
        rsp_q_nxt        = rsp_q;
        rsp_wrap_nxt     = rsp_wrap;
        cntr_data_in_nxt = 8'h00;
        cntr_ld_nxt      = 1'b0;
        cntr_inc_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt          = ISSUE;
                    owner_nxt          = win_idx;
                    op_ld_nxt          = req_ld[win_idx];
                    op_data_nxt        = data_arr[win_idx];
                    ptr_nxt            = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + ID_W'(1);
                    gnt_nxt[win_idx]   = 1'b1;
                    cntr_ld_nxt        = req_ld[win_idx];
                    cntr_inc_nxt       = !req_ld[win_idx];
                    cntr_data_in_nxt   = req_ld[win_idx] ? data_arr[win_idx] : 8'h00;
                end
            end
            ISSUE: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt    = IDLE;
                done_nxt     = 1'b1;
                done_id_nxt  = owner;
                rsp_q_nxt    = cntr_q;
                rsp_wrap_nxt = !op_ld && (cntr_q == 8'h00);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; synchronous active-low reset abandons
    // any operation in flight without producing done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            op_ld        <= 1'b0;
            op_data      <= 8'h00;
            gnt          <= '0;
            done         <= 1'b0;
            done_id      <= '0;
            rsp_q        <= 8'h00;
            rsp_wrap     <= 1'b0;
            busy         <= 1'b0;
            cntr_data_in <= 8'h00;
            cntr_ld      <= 1'b0;
            cntr_inc     <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            owner        <= owner_nxt;
            op_ld        <= op_ld_nxt;
            op_data      <= op_data_nxt;
            gnt          <= gnt_nxt;
            done         <= done_nxt;
            done_id      <= done_id_nxt;
            rsp_q        <= rsp_q_nxt;
            rsp_wrap     <= rsp_wrap_nxt;
            busy         <= busy_nxt;
            cntr_data_in <= cntr_data_in_nxt;
            cntr_ld      <= cntr_ld_nxt;
            cntr_inc     <= cntr_inc_nxt;
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: models the shared counter, drives directed and
// random request batches, and checks every done against a scoreboard queue.
module tb_counter_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_ld;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic                 done;
    logic [ID_W-1:0]      done_id;
    logic [7:0]           rsp_q;
    logic                 rsp_wrap;
    logic                 busy;
    logic [7:0]           cntr_data_in;
    logic                 cntr_ld;
    logic                 cntr_inc;
    logic [7:0]           cntr_q;

    counter_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ld(req_ld), .req_data(req_data),
        .gnt(gnt), .done(done), .done_id(done_id), .rsp_q(rsp_q), .rsp_wrap(rsp_wrap),
        .busy(busy), .cntr_data_in(cntr_data_in), .cntr_ld(cntr_ld),
        .cntr_inc(cntr_inc), .cntr_q(cntr_q)
    );

    always #5 clk = ~clk;

    // The shared counter: load wins over increment, wraps 0xFF -> 0x00.
    logic [7:0] cnt = 8'h00;
    always @(posedge clk) begin
        if (cntr_ld) cnt <= cntr_data_in;
        else if (cntr_inc) cnt <= cnt + 8'd1;
    end
    assign cntr_q = cnt;

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_done = -1;
    logic space_on = 1'b0;
    logic [7:0] ref_cnt = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop and per-cycle invariants, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!space_on) last_done = -1;
        if (rst) begin
            chk("mutex_ld_inc", 32'(cntr_ld & cntr_inc), 0);
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_id", 32'(done_id), e.id);
                    chk("rsp_q", 32'(rsp_q), 32'(e.q));
                    chk("rsp_wrap", 32'(rsp_wrap), 32'(e.wrap));
                    if (space_on && last_done >= 0) chk("done_spacing", cyc - last_done, 3);
                    last_done = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req = req & ~gnt;
    endtask

    task automatic post(input int i, input logic ld, input logic [7:0] d);
        req[i]            = 1'b1;
        req_ld[i]         = ld;
        req_data[8*i +: 8] = d;
    endtask

    task automatic push_exp(input int i, input logic ld, input logic [7:0] d);
        exp_t e;
        if (ld) ref_cnt = d;
        else ref_cnt = ref_cnt + 8'd1;
        e.id   = i;
        e.q    = ref_cnt;
        e.wrap = !ld && (ref_cnt == 8'h00);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            tick();
            if (!busy && exp_q.size() == 0 && req == '0) return;
        end
        chk("idle_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_done_id"}, 32'(done_id), 0);
        chk({tag, "_rsp_q"}, 32'(rsp_q), 0);
        chk({tag, "_rsp_wrap"}, 32'(rsp_wrap), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cntr_ld"}, 32'(cntr_ld), 0);
        chk({tag, "_cntr_inc"}, 32'(cntr_inc), 0);
        chk({tag, "_cntr_data_in"}, 32'(cntr_data_in), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nops;
        int         m_ptr;
        int         last;
        logic [3:0] mask;
        logic       lds [NUM_REQ];
        logic [7:0] ds  [NUM_REQ];

        rst = 1'b0; req = '0; req_ld = '0; req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single load by requester 1.
        post(1, 1'b1, 8'h5A);
        push_exp(1, 1'b1, 8'h5A);
        tick();
        chk("ld_gnt", 32'(gnt), 32'h2);
        chk("ld_cntr_ld", 32'(cntr_ld), 1);
        chk("ld_cntr_inc", 32'(cntr_inc), 0);
        chk("ld_data_in", 32'(cntr_data_in), 32'h5A);
        chk("ld_busy", 32'(busy), 1);
        tick();
        chk("ld_cntr_ld_low", 32'(cntr_ld), 0);
        chk("ld_gnt_low", 32'(gnt), 0);
        tick();
        chk("ld_done", 32'(done), 1);
        chk("ld_done_id", 32'(done_id), 1);
        chk("ld_busy_idle", 32'(busy), 0);
        wait_idle();

        // Load 0xFF then requester 2 increments through the wrap.
        post(0, 1'b1, 8'hFF);
        push_exp(0, 1'b1, 8'hFF);
        wait_idle();
        post(2, 1'b0, 8'hA5);
        push_exp(2, 1'b0, 8'hA5);
        tick();
        chk("inc_gnt", 32'(gnt), 32'h4);
        chk("inc_cntr_inc", 32'(cntr_inc), 1);
        chk("inc_cntr_ld", 32'(cntr_ld), 0);
        chk("inc_data_in", 32'(cntr_data_in), 0);
        wait_idle();

        // Pointer now at 3: requesters 0 and 3 together, 3 must win first.
        post(0, 1'b0, 8'h00);
        post(3, 1'b1, 8'h10);
        push_exp(3, 1'b1, 8'h10);
        push_exp(0, 1'b0, 8'h00);
        tick();
        chk("rot_gnt", 32'(gnt), 32'h8);
        wait_idle();

        // Fairness from reset: all four hold req, dones 3 cycles apart.
        rst = 1'b0;
        tick();
        tick();
        check_reset("rst_fair");
        rst = 1'b1;
        space_on = 1'b1;
        post(0, 1'b1, 8'h80);
        post(1, 1'b0, 8'h00);
        post(2, 1'b0, 8'h00);
        post(3, 1'b1, 8'h01);
        push_exp(0, 1'b1, 8'h80);
        push_exp(1, 1'b0, 8'h00);
        push_exp(2, 1'b0, 8'h00);
        push_exp(3, 1'b1, 8'h01);
        wait_idle();
        space_on = 1'b0;
        post(0, 1'b0, 8'h00);
        push_exp(0, 1'b0, 8'h00);
        tick();
        chk("fair_regrant", 32'(gnt), 32'h1);
        wait_idle();

        // Reset during ISSUE of a load of 0x33 by requester 2.
        post(2, 1'b1, 8'h33);
        tick();
        chk("rst_mid_gnt", 32'(gnt), 32'h4);
        rst = 1'b0;
        tick();
        check_reset("rst_mid");
        ref_cnt = 8'h33;
        tick();
        chk("rst_mid_no_done", 32'(done), 0);
        rst = 1'b1;
        post(0, 1'b0, 8'h00);
        post(3, 1'b1, 8'h99);
        push_exp(0, 1'b0, 8'h00);
        push_exp(3, 1'b1, 8'h99);
        tick();
        chk("rst_first_gnt", 32'(gnt), 32'h1);
        wait_idle();
        m_ptr = 0;

        // Random batches of concurrent requests until 1000 operations issued.
        nops = 0;
        while (nops < 1000) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++) begin
                lds[i] = 1'($urandom_range(0, 1));
                ds[i]  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            end
            last = m_ptr;
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_REQ;
                if (mask[idx]) begin
                    post(idx, lds[idx], ds[idx]);
                    push_exp(idx, lds[idx], ds[idx]);
                    last = idx;
                    nops++;
                end
            end
            m_ptr = (last + 1) % NUM_REQ;
            wait_idle();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
